// File: rtl/avalon_stream_sink.sv
// rtl/avalon_stream_sink.sv - Avalon-MM slave feeding a FWFT FIFO onto a valid/ready stream; optional pop counter under STREAM_SINK_STATS_EN
module avalon_stream_sink #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic              out_valid,
  output logic [31:0]       out_data,
  input  logic              out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];

  logic          empty, full;
  logic [PW-1:0] level;
  logic          rd_wait, wr_done, push, pop, flush;
  logic [31:0]   wdata_masked, status_word, stats_value, reg_value;

  // FIFO occupancy derived from the extra-MSB pointer pair
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level = wr_ptr_q - rd_ptr_q;
  end

  // Bus handshake; a read always takes priority over a concurrent write
  always_comb begin
    avs_waitrequest = 1'b0;
    if (!sys_rst) begin
      if (avs_read) avs_waitrequest = rd_wait;
      else          avs_waitrequest = full && avs_write && (avs_address == ADDR_W'(0));
    end
    wr_done = avs_write && !avs_read && !avs_waitrequest;
    push    = wr_done && (avs_address == ADDR_W'(0));
    flush   = wr_done && (avs_address == ADDR_W'(2)) && avs_writedata[0];
    pop     = !empty && out_ready;
  end

  // Disabled byte lanes are stored as zero
  always_comb begin
    wdata_masked = '0;
    for (int i = 0; i < 4; i++) begin
      if (avs_byteenable[i]) wdata_masked[8*i +: 8] = avs_writedata[8*i +: 8];
    end
  end

  // Register read mux: STATUS and STATS are the only readable offsets
  always_comb begin
    status_word       = '0;
    status_word[0]    = empty;
    status_word[1]    = full;
    status_word[15:8] = 8'(level);
    reg_value         = '0;
    if (avs_address == ADDR_W'(1)) reg_value = status_word;
    if (avs_address == ADDR_W'(3)) reg_value = stats_value;
  end

  // Read FSM: IDLE stalls one cycle and captures, RESP completes the transfer
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rd_wait = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avs_read) begin
          rd_wait = 1'b1;
          rdata_d = reg_value;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer update; flush discards everything by jumping the read pointer and beats a pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (flush)    rd_ptr_d = wr_ptr_q;
    else if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Control/state registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_masked;
  end

`ifdef STREAM_SINK_STATS_EN
  logic [31:0] stats_q, stats_d;

  // Popped-word counter; a clearing write beats a concurrent pop
  always_comb begin
    stats_d = stats_q;
    if (wr_done && (avs_address == ADDR_W'(3))) stats_d = '0;
    else if (pop && !flush)                     stats_d = stats_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) stats_q <= '0;
    else         stats_q <= stats_d;
  end

  assign stats_value = stats_q;
`else
  assign stats_value = '0;
`endif

  assign avs_readdata = rdata_q;
  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: doc/avalon_stream_sink.md
Name: avalon_stream_sink

Overview:
- Avalon-MM slave (responder) that closes the host-driven stream bus currently tied off in the top level (waitrequest=1, readdata=0).
- Accepts 32-bit word writes from the HPS side into a synchronous FIFO and presents them on a valid/ready stream for the downstream video path.
- Exposes status and control registers on the same bus.
- Single clock domain (sys_clk, 100 MHz). Replaces the tie-off assigns in Top.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of two, >= 4.
ADDR_W, 2, word-address width of the slave; register map uses offsets 0..3.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  reset, asynchronous, active-high
avs_address  input  ADDR_W  word offset
avs_write  input  1  write request
avs_writedata  input  32  write data
avs_byteenable  input  4  byte lanes for writes
avs_read  input  1  read request
avs_readdata  output  32  read data, valid when avs_read && !avs_waitrequest
avs_waitrequest  output  1  slave stall
out_valid  output  1  stream word available
out_data  output  32  stream word (FIFO head, first-word-fall-through)
out_ready  input  1  downstream accepts word when out_valid && out_ready

Behaviour:
- Reset (async on sys_rst rise): FIFO empty, read/write pointers 0, out_valid=0, out_data=0, avs_readdata=0, read FSM in IDLE.
- avs_waitrequest: 0 during reset and while idle.
- Register map:
  - 0 DATA: write pushes a word. Bytes with byteenable=0 are stored as 0x00. Reads return 0.
  - 1 STATUS (read): bit0 empty, bit1 full, bits[15:8] fill level (zero-extended). Writes ignored.
  - 2 CONTROL (write): bit0=1 flushes the FIFO. Reads return 0.
  - 3 STATS: see Optional Feature.
- Write handshake: avs_waitrequest = full && avs_write && avs_address==0 (combinational).
  - A write completes in the cycle avs_write && !avs_waitrequest.
  - Writes to offsets 1 and 3 complete immediately with no effect.
- Read FSM, states IDLE and RESP:
  - IDLE + avs_read: waitrequest=1, capture the register into avs_readdata at the clock edge, go to RESP.
  - RESP: waitrequest=0 (transfer completes), return to IDLE.
  - Fixed read latency: 2 cycles per read. A back-to-back read re-enters RESP after IDLE.
  - read and write asserted together: illegal; the write is ignored and the read is served.
- Stream side: out_valid = !empty; out_data = mem[rd_ptr] (combinational FWFT). A pop occurs when out_valid && out_ready.
- Simultaneous push and pop, not full: level unchanged, both pointers advance.
- Full: push stalled via waitrequest. A pop in the same cycle does not release the stalled write until the next cycle (no lookahead).
- Empty: out_ready is ignored and no pointer moves.
- Pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
  - full when MSBs differ and the low bits are equal; empty when all bits are equal.
  - level = wr_ptr - rd_ptr (unsigned, modulo).
- Flush: takes effect at the clock edge of the completing CONTROL write; rd_ptr <= wr_ptr. Flush wins over a concurrent pop. out_valid=0 the following cycle.
- Reset mid-transfer: pending read is abandoned, waitrequest returns to 0, FIFO contents are discarded.

Optional Feature:
- Macro STREAM_SINK_STATS_EN.
- Defined: a 32-bit counter of popped words.
  - Increments on each pop and wraps at 2^32.
  - Readable at offset 3; a write of any value to offset 3 clears it.
  - Cleared by reset; not cleared by flush.
- Undefined: no counter logic; offset 3 reads 0 and writes are ignored.

Test Plan:
- Reset then read STATUS -> read completes on 2nd cycle, readdata=0x0000_0001, out_valid=0.
- Write 0xDEADBEEF (byteenable 0xF) to offset 0 with out_ready=0 -> out_valid=1 next cycle, out_data=0xDEADBEEF, STATUS=0x0000_0100.
- Write 0x11223344 with byteenable 0x5 -> out_data=0x00220044.
- Push 16 words (DEPTH=16), out_ready=0 -> STATUS=0x0000_1002; 17th write holds waitrequest=1; pulse out_ready one cycle -> 17th write completes the following cycle, level=16, first word popped, order preserved.
- Fill 5 words, write 0x1 to offset 2 while out_ready=1 -> out_valid=0 after flush, STATUS=0x0000_0001; a following push of 0xA5A5A5A5 -> out_data=0xA5A5A5A5.
- STREAM_SINK_STATS_EN: stream 40 words continuously (push and pop every cycle, covering pointer wrap) -> data matches in order, offset 3 reads 40; write offset 3 -> reads 0. Without macro: offset 3 reads 0.
